// File: rtl/dc1_xbit_scrub_pkg.sv
// Shared dc1 xbit definitions: word geometry, scrubber FSM states and the
// byte-parity check used by the pbit RAM scrubber.
package dc1_xbit_scrub_pkg;

  localparam int XBIT_W       = 36;
  localparam int XBIT_GROUPS  = 4;
  localparam int XBIT_GROUP_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RREQ  = 3'd1,
    ST_RDATA = 3'd2,
    ST_WREQ  = 3'd3,
    ST_NEXT  = 3'd4
  } scrub_state_t;

  // A group is bad when its 8 data bits plus parity bit XOR to 1.
  function automatic logic [XBIT_GROUPS-1:0] xbit_par_chk(input logic [XBIT_W-1:0] word);
    logic [XBIT_GROUPS-1:0] mask;
    mask = '0;
    for (int i = 0; i < XBIT_GROUPS; i++) begin
      mask[i] = ^word[i*XBIT_GROUP_W +: XBIT_GROUP_W];
    end
    return mask;
  endfunction

endpackage

// File: rtl/dc1_xbit_par_chk.sv
// Combinational xbit word checker: flags failing byte-parity groups and
// produces the repaired word with every failing group forced to zero.
module dc1_xbit_par_chk
  import dc1_xbit_scrub_pkg::*;
(
  input  logic [XBIT_W-1:0]      word,
  output logic [XBIT_GROUPS-1:0] bad_mask,
  output logic [XBIT_W-1:0]      fixed_word
);

  // Check all groups, then zero the failing ones in a copy of the word.
  always_comb begin
    bad_mask   = xbit_par_chk(word);
    fixed_word = word;
    for (int i = 0; i < XBIT_GROUPS; i++) begin
      if (bad_mask[i]) begin
        fixed_word[i*XBIT_GROUP_W +: XBIT_GROUP_W] = '0;
      end
    end
  end

endmodule

// File: rtl/dc1_xbit_scrub.sv
// Background scrubber for the dcache xbit (pbit) RAM. Walks every {row, bank}
// word through a borrowed read port, checks the four byte-parity groups and
// logs/counts failing words. Pointer is {row, bank} with bank as the LSB, so
// the bank toggles before the row advances.
// Optional write-back of the repaired word is compiled in when the macro
// DC1_XBIT_SCRUB_FIX_EN is defined; otherwise the block is report-only and
// the write port outputs are tied to zero.
module dc1_xbit_scrub
  import dc1_xbit_scrub_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int INTERVAL   = 256,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scrub_en,
  output logic                   rd_req,
  input  logic                   rd_gnt,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   rd_bank,
  input  logic [XBIT_W-1:0]      rd_data,
  output logic                   wr_req,
  input  logic                   wr_gnt,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic                   wr_bank,
  output logic [XBIT_W-1:0]      wr_data,
  input  logic                   snoop_valid,
  input  logic [ADDR_WIDTH-1:0]  snoop_addr,
  input  logic                   snoop_bank,
  input  logic                   err_clr,
  output logic                   err_valid,
  output logic [ADDR_WIDTH-1:0]  err_addr,
  output logic                   err_bank,
  output logic [XBIT_GROUPS-1:0] err_bytes,
  output logic [CNT_W-1:0]       err_count,
  output logic                   sweep_done,
  output logic                   busy
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int IVL_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [IVL_W-1:0] IVL_RELOAD = IVL_W'(INTERVAL - 1);

  scrub_state_t           state;
  logic [PTR_W-1:0]       ptr;
  logic [IVL_W-1:0]       ivl_cnt;
  logic [XBIT_GROUPS-1:0] bad_mask;
  logic [XBIT_W-1:0]      fixed_word;
  logic                   has_err;
  logic                   snoop_hit;

  dc1_xbit_par_chk u_par_chk (
    .word       (rd_data),
    .bad_mask   (bad_mask),
    .fixed_word (fixed_word)
  );

  assign has_err = |bad_mask;

  // The pointer does not move between RREQ and NEXT, so it names the word in flight.
  assign snoop_hit = snoop_valid && (snoop_addr == ptr[PTR_W-1:1]) && (snoop_bank == ptr[0]);

  assign rd_addr = ptr[PTR_W-1:1];
  assign rd_bank = ptr[0];

`ifndef DC1_XBIT_SCRUB_FIX_EN
  logic unused_fix;
  assign unused_fix = ^{wr_gnt, fixed_word, snoop_hit};
  assign wr_req  = 1'b0;
  assign wr_addr = '0;
  assign wr_bank = 1'b0;
  assign wr_data = '0;
`endif

  // Scrub FSM: interval wait, read, check/log, optional repair write, advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      ivl_cnt    <= IVL_RELOAD;
      rd_req     <= 1'b0;
      busy       <= 1'b0;
      err_valid  <= 1'b0;
      err_addr   <= '0;
      err_bank   <= 1'b0;
      err_bytes  <= '0;
      err_count  <= '0;
      sweep_done <= 1'b0;
`ifdef DC1_XBIT_SCRUB_FIX_EN
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_bank    <= 1'b0;
      wr_data    <= '0;
`endif
    end else begin
      err_valid  <= 1'b0;
      sweep_done <= 1'b0;
      if (err_clr) begin
        err_count <= '0;
      end
      case (state)
        ST_IDLE: begin
          if (scrub_en) begin
            if (ivl_cnt == '0) begin
              ivl_cnt <= IVL_RELOAD;
              rd_req  <= 1'b1;
              busy    <= 1'b1;
              state   <= ST_RREQ;
            end else begin
              ivl_cnt <= ivl_cnt - 1'b1;
            end
          end
        end
        ST_RREQ: begin
          if (rd_gnt) begin
            rd_req <= 1'b0;
            state  <= ST_RDATA;
          end else if (!scrub_en) begin
            rd_req <= 1'b0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_RDATA: begin
          state <= ST_NEXT;
          if (has_err) begin
            err_valid <= 1'b1;
            err_addr  <= ptr[PTR_W-1:1];
            err_bank  <= ptr[0];
            err_bytes <= bad_mask;
            if (err_clr) begin
              err_count <= CNT_W'(1);
            end else if (!(&err_count)) begin
              err_count <= err_count + 1'b1;
            end
`ifdef DC1_XBIT_SCRUB_FIX_EN
            if (!snoop_hit) begin
              wr_req  <= 1'b1;
              wr_addr <= ptr[PTR_W-1:1];
              wr_bank <= ptr[0];
              wr_data <= fixed_word;
              state   <= ST_WREQ;
            end
`endif
          end
        end
`ifdef DC1_XBIT_SCRUB_FIX_EN
        ST_WREQ: begin
          if (wr_gnt || snoop_hit) begin
            wr_req <= 1'b0;
            state  <= ST_NEXT;
          end
        end
`endif
        ST_NEXT: begin
          ptr   <= ptr + 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (&ptr) begin
            sweep_done <= 1'b1;
          end
        end
        default: begin
          rd_req <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
